// File: rtl/coco_bus_timing_if.sv
// Purpose: bus bundle between the CoCo bus-timing sequencer and its clients (CPU, DMA channels, RAM).
// Latency: none, wires only.
// Backpressure: none; requests are pulses and the sequencer owns all RAM timing.
interface coco_bus_timing_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CH     = 2
);
    // clock phases
    logic                 rate;
    logic                 ena;
    logic                 e;
    logic                 q;
    logic [3:0]           ph;
    // CPU port
    logic [ADDR_W-1:0]    cpu_addr;
    logic                 cpu_we;
    logic [DATA_W-1:0]    cpu_wdata;
    logic [DATA_W-1:0]    cpu_rdata;
    // DMA read channels, channel 0 in the LSBs
    logic [CH-1:0]        ch_req;
    logic [CH*ADDR_W-1:0] ch_addr;
    logic [CH*DATA_W-1:0] ch_data;
    logic [CH-1:0]        ch_valid;
    // synchronous RAM port
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;
    // statistics
    logic [15:0]          drop_cnt;

    // sequencer side
    modport master (
        input  rate, cpu_addr, cpu_we, cpu_wdata, ch_req, ch_addr, mem_rdata,
        output ena, e, q, ph, cpu_rdata, ch_data, ch_valid,
               mem_addr, mem_rd, mem_wr, mem_wdata, drop_cnt
    );

    // CPU / DMA / RAM side
    modport slave (
        output rate, cpu_addr, cpu_we, cpu_wdata, ch_req, ch_addr, mem_rdata,
        input  ena, e, q, ph, cpu_rdata, ch_data, ch_valid,
               mem_addr, mem_rd, mem_wr, mem_wdata, drop_cnt
    );
endinterface

// File: rtl/coco_bus_timing.sv
// Purpose: CoCo bus timing: ena divider, 6809 E/Q phases, RAM slot sequencer for CPU + CH round-robin DMA readers.
// Latency: slot strobe in cycle T, RAM data valid in T+1, cpu_rdata/ch_data/ch_valid update at the end of T+1.
// Backpressure: none; a DMA re-request while still pending overwrites the address (counted when COCO_BUS_STATS_EN is defined).
module coco_bus_timing #(
    parameter int DIV    = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CH     = 2
) (
    input  logic               clk,
    input  logic               reset,
    coco_bus_timing_if.master  bus
);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RRW = 2;

    logic [DCW-1:0]               r_div;
    logic                         r_ena;
    logic [3:0]                   r_ph;
    logic                         r_rate;
    logic [CH-1:0]                r_pend;
    logic [CH-1:0][ADDR_W-1:0]    r_addr;
    logic [RRW-1:0]               r_rr;
    logic                         r_cap_cpu;
    logic [CH-1:0]                r_cap_ch;
    logic [DATA_W-1:0]            r_cpu_rdata;
    logic [CH-1:0][DATA_W-1:0]    r_ch_data;
    logic [CH-1:0]                r_ch_valid;

    logic [CH-1:0][ADDR_W-1:0]    w_ch_addr;
    logic                         w_slot_dma;
    logic                         w_slot_cpu;
    logic                         w_gnt_found;
    logic [RRW-1:0]               w_gnt_idx;
    int                           w_best;
    logic                         w_dma_rd;
    logic                         w_cpu_rd;
    logic                         w_cpu_wr;
    logic [CH-1:0]                w_grant;
    logic [ADDR_W-1:0]            w_dma_addr;

    assign w_ch_addr  = bus.ch_addr;
    assign w_slot_dma = r_ena && (r_ph == 4'd0 || r_ph == 4'd4);
    assign w_slot_cpu = r_ena && (r_ph == 4'd8);
    assign w_dma_rd   = w_slot_dma && w_gnt_found;
    assign w_cpu_rd   = w_slot_cpu && !bus.cpu_we;
    assign w_cpu_wr   = w_slot_cpu && bus.cpu_we;

    // master clock divider: ena is a registered one-clock pulse every DIV clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
            r_ena <= 1'b0;
        end else begin
            r_ena <= (r_div == DCW'(DIV - 1));
            r_div <= (r_div == DCW'(DIV - 1)) ? '0 : r_div + 1'b1;
        end
    end

    // phase counter; rate is only picked up at the end of an E cycle so cycles never get torn
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph   <= 4'd0;
            r_rate <= 1'b0;
        end else if (r_ena) begin
            if (r_ph >= 4'd14) begin
                r_rate <= bus.rate;
            end
            // wrap explicitly: a rate change sampled at 14 must not make 15 step by two
            if (r_ph == 4'd15 || (r_ph == 4'd14 && r_rate)) begin
                r_ph <= 4'd0;
            end else begin
                r_ph <= r_ph + (r_rate ? 4'd2 : 4'd1);
            end
        end
    end

    // round-robin pick: pending channel with the smallest distance from rr
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_best      = CH;
        for (int i = 0; i < CH; i++) begin
            if (r_pend[i] && ((i - int'(r_rr) + CH) % CH) < w_best) begin
                w_best      = (i - int'(r_rr) + CH) % CH;
                w_gnt_idx   = RRW'(i);
                w_gnt_found = 1'b1;
            end
        end
    end

    // one-hot grant and the latched address of the granted channel
    always_comb begin
        w_grant    = '0;
        w_dma_addr = '0;
        for (int i = 0; i < CH; i++) begin
            w_grant[i] = w_dma_rd && (w_gnt_idx == RRW'(i));
            if (w_grant[i]) begin
                w_dma_addr = r_addr[i];
            end
        end
    end

    // request capture; a request on the grant clock re-arms pend while the grant uses the old address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            r_addr <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (bus.ch_req[i]) begin
                    r_addr[i] <= w_ch_addr[i];
                    r_pend[i] <= 1'b1;
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // round-robin pointer moves past the granted channel; idle slots leave it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= '0;
        end else if (w_dma_rd) begin
            r_rr <= (w_gnt_idx == RRW'(CH - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // remember who owns the read in flight; reset here is what aborts an access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_cpu <= 1'b0;
            r_cap_ch  <= '0;
        end else begin
            r_cap_cpu <= w_cpu_rd;
            r_cap_ch  <= w_grant;
        end
    end

    // land RAM read data one clock after the strobe and pulse the channel valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_ch_data   <= '0;
            r_ch_valid  <= '0;
        end else begin
            if (r_cap_cpu) begin
                r_cpu_rdata <= bus.mem_rdata;
            end
            for (int i = 0; i < CH; i++) begin
                if (r_cap_ch[i]) begin
                    r_ch_data[i] <= bus.mem_rdata;
                end
            end
            r_ch_valid <= r_cap_ch;
        end
    end

`ifdef COCO_BUS_STATS_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    assign w_drop = |(bus.ch_req & r_pend & ~w_grant);

    // saturating drop counter; simultaneous drops count once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.drop_cnt = 16'd0;
`endif

    assign bus.ena       = r_ena;
    assign bus.ph        = r_ph;
    assign bus.e         = r_ph[3];
    assign bus.q         = r_ph[3] ^ r_ph[2];
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ch_data   = r_ch_data;
    assign bus.ch_valid  = r_ch_valid;
    assign bus.mem_rd    = w_dma_rd | w_cpu_rd;
    assign bus.mem_wr    = w_cpu_wr;
    assign bus.mem_addr  = w_dma_rd ? w_dma_addr : (w_slot_cpu ? bus.cpu_addr : '0);
    assign bus.mem_wdata = w_cpu_wr ? bus.cpu_wdata : '0;
endmodule

// File: tb/tb_coco_bus_timing.sv
// Testbench for coco_bus_timing: directed vectors plus hand-written slot sequences.
// Clock 10 ns, DUT outputs sampled on the falling edge, inputs changed on the falling edge.
// A small synchronous RAM model answers mem_rd one clock later.
module tb_coco_bus_timing;
    localparam int DIV    = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CH     = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc;

    always #5 clk = ~clk;

    coco_bus_timing_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH(CH)) bus ();

    coco_bus_timing #(.DIV(DIV), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH(CH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM: unwritten bytes read as addr_lo ^ addr_hi ^ 8'h3C
    bit [7:0] ram   [0:65535];
    bit       wflag [0:65535];

    function automatic logic [7:0] ram_val(input logic [15:0] a);
        logic [7:0] p;
        p = a[7:0] ^ a[15:8] ^ 8'h3C;
        return wflag[a] ? ram[a] : p;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_wr) begin
            ram[bus.mem_addr]   <= bus.mem_wdata;
            wflag[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_rd) begin
            bus.mem_rdata <= ram_val(bus.mem_addr);
        end
    end

    // clocks since reset release: sampled at the falling edge after rising edge n it reads n
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    // advance to the next clock where a slot for phase p fires
    task automatic wait_slot(input logic [3:0] p);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(bus.ena && bus.ph == p) && g < 400);
        if (g >= 400) timeout("wait_slot");
    endtask

    task automatic wait_e_fall(output int t);
        logic p;
        t = -1;
        p = bus.e;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (p && !bus.e) begin
                t = cyc;
                break;
            end
            p = bus.e;
        end
        if (t < 0) timeout("wait_e_fall");
    endtask

    // at a DMA slot: strobe/address now, nothing next clock, valid+data the clock after
    task automatic dma_exp(input string nm, input logic [15:0] a, input int c, input logic [7:0] d);
        chk({nm, "_rd"},   32'(bus.mem_rd), 1);
        chk({nm, "_addr"}, 32'(bus.mem_addr), 32'(a));
        @(negedge clk);
        chk({nm, "_vld_early"}, 32'(bus.ch_valid), 0);
        @(negedge clk);
        chk({nm, "_vld"}, 32'(bus.ch_valid), 32'(1 << c));
        chk({nm, "_dat"}, 32'(bus.ch_data[c*8 +: 8]), 32'(d));
    endtask

    task automatic pulse_req(input logic [1:0] r, input logic [15:0] a0, input logic [15:0] a1);
        bus.ch_addr = {a1, a0};
        bus.ch_req  = r;
        @(negedge clk);
        bus.ch_req  = 2'b00;
        @(negedge clk);
    endtask

    typedef struct {
        int         n;
        logic       ena;
        logic [3:0] ph;
        logic       e;
        logic       q;
        logic       mem_rd;
    } vec_t;

    vec_t vt[13];

    initial begin
        int t0, t1, t2, t3, t4, t5, g;

        vt[0]  = '{1,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        vt[1]  = '{3,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        vt[2]  = '{4,  1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
        vt[3]  = '{5,  1'b0, 4'd1,  1'b0, 1'b0, 1'b0};
        vt[4]  = '{8,  1'b1, 4'd1,  1'b0, 1'b0, 1'b0};
        vt[5]  = '{16, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0};
        vt[6]  = '{17, 1'b0, 4'd4,  1'b0, 1'b1, 1'b0};
        vt[7]  = '{20, 1'b1, 4'd4,  1'b0, 1'b1, 1'b0};
        vt[8]  = '{33, 1'b0, 4'd8,  1'b1, 1'b1, 1'b0};
        vt[9]  = '{36, 1'b1, 4'd8,  1'b1, 1'b1, 1'b1};
        vt[10] = '{49, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0};
        vt[11] = '{64, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0};
        vt[12] = '{65, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};

        bus.rate      = 1'b0;
        bus.cpu_addr  = 16'h0000;
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = 8'h00;
        bus.ch_req    = 2'b00;
        bus.ch_addr   = 32'h0;

        // reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ena",   32'(bus.ena), 0);
        chk("rst_ph",    32'(bus.ph), 0);
        chk("rst_eq",    32'({bus.e, bus.q}), 0);
        chk("rst_strb",  32'({bus.mem_rd, bus.mem_wr}), 0);
        chk("rst_addr",  32'(bus.mem_addr), 0);
        chk("rst_vld",   32'(bus.ch_valid), 0);
        chk("rst_cpu",   32'(bus.cpu_rdata), 0);
        chk("rst_drop",  32'(bus.drop_cnt), 0);
        reset = 1'b0;

        // divider and phases
        for (int i = 0; i < 13; i++) begin
            g = 0;
            while (cyc < vt[i].n && g < 200) begin
                @(negedge clk);
                g++;
            end
            chk($sformatf("vec%0d_ena", vt[i].n), 32'(bus.ena), 32'(vt[i].ena));
            chk($sformatf("vec%0d_ph", vt[i].n),  32'(bus.ph),  32'(vt[i].ph));
            chk($sformatf("vec%0d_e", vt[i].n),   32'(bus.e),   32'(vt[i].e));
            chk($sformatf("vec%0d_q", vt[i].n),   32'(bus.q),   32'(vt[i].q));
            chk($sformatf("vec%0d_rd", vt[i].n),  32'(bus.mem_rd), 32'(vt[i].mem_rd));
        end

        // rate switch mid-cycle: current E cycle unaffected, then 32-clock cycles
        wait_e_fall(t0);
        g = 0;
        while (bus.ph != 4'd5 && g < 100) begin
            @(negedge clk);
            g++;
        end
        bus.rate = 1'b1;
        wait_e_fall(t1);
        chk("ecyc_switch", 32'(t1 - t0), 64);
        wait_e_fall(t2);
        chk("ecyc_fast1", 32'(t2 - t1), 32);
        wait_e_fall(t3);
        chk("ecyc_fast2", 32'(t3 - t2), 32);
        for (int k = 1; k <= 3; k++) begin
            repeat (4) @(negedge clk);
            chk($sformatf("fast_ph%0d", k), 32'(bus.ph), 32'(2 * k));
        end
        bus.rate = 1'b0;
        wait_e_fall(t4);
        wait_e_fall(t5);
        chk("ecyc_back_normal", 32'(t5 - t4), 64);

        // CPU write then read back
        bus.cpu_addr  = 16'h0400;
        bus.cpu_wdata = 8'hA5;
        bus.cpu_we    = 1'b1;
        wait_slot(4'd8);
        chk("cpu_wr_strb", 32'({bus.mem_wr, bus.mem_rd}), 32'h2);
        chk("cpu_wr_addr", 32'(bus.mem_addr), 32'h0400);
        chk("cpu_wr_data", 32'(bus.mem_wdata), 32'hA5);
        @(negedge clk);
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = 8'h00;
        wait_slot(4'd8);
        chk("cpu_rd_strb", 32'({bus.mem_wr, bus.mem_rd}), 32'h1);
        chk("cpu_rd_addr", 32'(bus.mem_addr), 32'h0400);
        @(negedge clk);
        chk("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'h3C);
        @(negedge clk);
        chk("cpu_rdata", 32'(bus.cpu_rdata), 32'hA5);

        // round-robin: ch0 alone moves rr to 1, then both pending -> ch1 first
        pulse_req(2'b01, 16'h0400, 16'h8000);
        wait_slot(4'd0);
        dma_exp("rr_a0", 16'h0400, 0, 8'hA5);
        wait_slot(4'd4);
        chk("rr_idle_b", 32'(bus.mem_rd), 0);
        @(negedge clk);
        pulse_req(2'b11, 16'h0400, 16'h8000);
        wait_slot(4'd0);
        dma_exp("rr_a1", 16'h8000, 1, 8'hBC);
        wait_slot(4'd4);
        dma_exp("rr_b0", 16'h0400, 0, 8'hA5);
        pulse_req(2'b11, 16'h0400, 16'h8000);
        wait_slot(4'd0);
        dma_exp("rr_a1b", 16'h8000, 1, 8'hBC);
        wait_slot(4'd4);
        dma_exp("rr_b0b", 16'h0400, 0, 8'hA5);

        // request on the grant clock: old address served, new one stays pending
        pulse_req(2'b01, 16'h0400, 16'h8000);
        wait_slot(4'd0);
        bus.ch_addr = {16'h8000, 16'h2222};
        bus.ch_req  = 2'b01;
        #1;
        chk("coll_rd",   32'(bus.mem_rd), 1);
        chk("coll_addr", 32'(bus.mem_addr), 32'h0400);
        @(negedge clk);
        bus.ch_req = 2'b00;
        chk("coll_vld_early", 32'(bus.ch_valid), 0);
        @(negedge clk);
        chk("coll_vld", 32'(bus.ch_valid), 1);
        chk("coll_dat", 32'(bus.ch_data[7:0]), 32'hA5);
        wait_slot(4'd4);
        dma_exp("coll_b", 16'h2222, 0, 8'h3C);
        chk("coll_no_drop", 32'(bus.drop_cnt), 0);

        // three requests between slots: the last address wins
        pulse_req(2'b01, 16'h1111, 16'h8000);
        pulse_req(2'b01, 16'h2222, 16'h8000);
        pulse_req(2'b01, 16'h0400, 16'h8000);
        wait_slot(4'd0);
        dma_exp("drop_svc", 16'h0400, 0, 8'hA5);
`ifdef COCO_BUS_STATS_EN
        chk("drop_cnt", 32'(bus.drop_cnt), 2);
`else
        chk("drop_cnt", 32'(bus.drop_cnt), 0);
`endif
        wait_slot(4'd4);
        chk("drop_single_svc", 32'(bus.mem_rd), 0);

        // reset on the clock of a DMA read
        pulse_req(2'b10, 16'h0400, 16'h8000);
        wait_slot(4'd0);
        chk("rst_mid_strobe", 32'(bus.mem_rd), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_rd_off", 32'(bus.mem_rd), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_vld%0d", k), 32'(bus.ch_valid), 0);
        end
        chk("rst_mid_ena",  32'(bus.ena), 0);
        chk("rst_mid_ph",   32'(bus.ph), 0);
        chk("rst_mid_eq",   32'({bus.e, bus.q}), 0);
        chk("rst_mid_addr", 32'(bus.mem_addr), 0);
        chk("rst_mid_wd",   32'(bus.mem_wdata), 0);
        chk("rst_mid_cpu",  32'(bus.cpu_rdata), 0);
        chk("rst_mid_chd",  32'(bus.ch_data), 0);
        chk("rst_mid_drop", 32'(bus.drop_cnt), 0);
        reset = 1'b0;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.ena && g < 20);
        chk("restart_ena_clk", 32'(cyc), 4);
        wait_slot(4'd0);
        chk("restart_idle_a", 32'(bus.mem_rd), 0);
        wait_slot(4'd8);
        chk("restart_cpu_rd", 32'(bus.mem_rd), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
